// File: rtl/xfilter_seq.sv
// rtl/xfilter_seq.sv - raster sequencer for the 3-tap horizontal filter stage
module xfilter_seq #(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int PB = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [XB-1:0] i_width,
    input  logic [YB-1:0] i_height,
    input  logic          s_valid,
    input  logic [PB+1:0] s_pixel,
    output logic          s_ready,
    output logic          o_valid_new_pixel,
    output logic [PB+1:0] o_new_pixel,
    output logic          o_valid_lpos,
    output logic          o_valid_cpos,
    output logic          o_valid_rpos,
    output logic          o_rowM,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]    state;
    logic [XB-1:0] col;
    logic [YB-1:0] row;
    logic [1:0]    drain;
    logic [XB-1:0] w_q;
    logic [YB-1:0] h_q;
    logic          err_q;

    logic size_ok;
    logic last_row;
    logic last_col;
    logic push;

    // Decode handshake, strobes and status from the current position
    always_comb begin
        size_ok  = (i_width >= XB'(2)) && (i_height >= YB'(1));
        last_row = (row == h_q - YB'(1));
        last_col = (col == w_q - XB'(1));
        s_ready  = (state == ST_RUN) || ((state == ST_FLUSH) && !last_row);
        push     = s_valid && s_ready;

        o_valid_new_pixel = push;
        o_new_pixel       = s_pixel;
        // In FLUSH the push is pixel 0 of the next row, so it carries no strobe
        o_valid_lpos = (state == ST_RUN) && push && (col == XB'(1));
        o_valid_cpos = (state == ST_RUN) && push && (col >= XB'(2));
        o_valid_rpos = (state == ST_FLUSH);
        o_rowM       = ((state == ST_RUN) || (state == ST_FLUSH)) && last_row;
        o_busy       = (state != ST_IDLE);
        o_done       = (state == ST_DRAIN) && (drain == 2'd1);
        o_err        = err_q;
    end

    // Frame sequencing: column/row counters and the drain countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
            drain <= '0;
            w_q   <= '0;
            h_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start && size_ok) begin
                        w_q   <= i_width;
                        h_q   <= i_height;
                        col   <= '0;
                        row   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        if (last_col) begin
                            col   <= '0;
                            state <= ST_FLUSH;
                        end else begin
                            col <= col + XB'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (push) begin
                        col <= XB'(1);
                    end
                    if (last_row) begin
                        drain <= 2'd3;
                        state <= ST_DRAIN;
                    end else begin
                        row   <= row + YB'(1);
                        state <= ST_RUN;
                    end
                end
                default: begin
                    drain <= drain - 2'd1;
                    if (drain == 2'd1) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Single-cycle error pulse for a start request with an unusable frame size
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == ST_IDLE) && i_start && !size_ok;
        end
    end

endmodule

// File: tb/tb_xfilter_seq.sv
// tb/tb_xfilter_seq.sv - randomized scoreboard bench for xfilter_seq
module tb_xfilter_seq;

    localparam int XB = 10;
    localparam int YB = 10;
    localparam int PB = 8;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic [XB-1:0] i_width;
    logic [YB-1:0] i_height;
    logic          s_valid;
    logic [PB+1:0] s_pixel;
    logic          s_ready;
    logic          o_valid_new_pixel;
    logic [PB+1:0] o_new_pixel;
    logic          o_valid_lpos;
    logic          o_valid_cpos;
    logic          o_valid_rpos;
    logic          o_rowM;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    int n_vec;
    int n_err;

    xfilter_seq #(.XB(XB), .YB(YB), .PB(PB)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_start           (i_start),
        .i_width           (i_width),
        .i_height          (i_height),
        .s_valid           (s_valid),
        .s_pixel           (s_pixel),
        .s_ready           (s_ready),
        .o_valid_new_pixel (o_valid_new_pixel),
        .o_new_pixel       (o_new_pixel),
        .o_valid_lpos      (o_valid_lpos),
        .o_valid_cpos      (o_valid_cpos),
        .o_valid_rpos      (o_valid_rpos),
        .o_rowM            (o_rowM),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err             (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {ready, push, L, C, R, rowM, busy, done, err}
    function automatic logic [8:0] outs();
        return {s_ready, o_valid_new_pixel, o_valid_lpos, o_valid_cpos,
                o_valid_rpos, o_rowM, o_busy, o_done, o_err};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        i_start = 1'b1;
        i_width = 10'd4;
        i_height = 10'd2;
        s_valid = 1'b1;
        s_pixel = 10'h2a5;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (outs() !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outs got=%b exp=%b", outs(), 9'b0);
        end
        n_vec++;
        if (o_new_pixel !== 10'h2a5) begin
            n_err++;
            $display("FAIL reset_pixel got=%h exp=%h", o_new_pixel, 10'h2a5);
        end
        i_start = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // mode: 0 = valid always, 1 = valid toggling, 2 = random gaps.
    // inject: re-pulse i_start mid-frame with another size. abort: cycle to reset at (-1 none).
    task automatic run_frame(input int w, input int h, input int mode,
                             input bit inject, input int abort);
        int total, p, drain_left, cyc, bound;
        bit flush, fin, v, rdy;
        logic [8:0] exp;
        int cl, cc, cr, cp;
        total = w * h;
        p = 0; drain_left = 0; flush = 0; fin = 0; cyc = 0;
        cl = 0; cc = 0; cr = 0; cp = 0;
        bound = 8 * total + 50;

        @(negedge clk);
        i_start = 1'b1;
        i_width = XB'(w);
        i_height = YB'(h);
        s_valid = 1'b0;
        #1;
        n_vec++;
        if (outs() !== 9'b0) begin
            n_err++;
            $display("FAIL start_idle w=%0d h=%0d got=%b exp=%b", w, h, outs(), 9'b0);
        end
        @(negedge clk);
        i_start = 1'b0;

        while (!fin) begin
            if (cyc >= bound) begin
                n_vec++;
                n_err++;
                $display("FAIL frame_timeout w=%0d h=%0d pushes=%0d exp=%0d", w, h, p, total);
                return;
            end
            case (mode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s_valid = v;
            s_pixel = PB'($urandom) | 10'(($urandom & 3) << PB);
            i_start = inject && (cyc == 2);
            i_width = inject ? XB'(9) : XB'(w);
            i_height = inject ? YB'(5) : YB'(h);

            if (cyc == abort) begin
                rst = 1'b0;
                #1;
                n_vec++;
                if (outs() !== 9'b0) begin
                    n_err++;
                    $display("FAIL abort_outs got=%b exp=%b", outs(), 9'b0);
                end
                @(negedge clk);
                i_start = 1'b0;
                s_valid = 1'b0;
                #1;
                n_vec++;
                if ({o_busy, o_done} !== 2'b00) begin
                    n_err++;
                    $display("FAIL abort_nodone busy/done got=%b exp=00", {o_busy, o_done});
                end
                rst = 1'b1;
                @(negedge clk);
                return;
            end

            // Expected behaviour from the frame's position in pixel order
            if (drain_left > 0) begin
                exp = {1'b0, 1'b0, 3'b000, 1'b0, 1'b1, drain_left == 1, 1'b0};
            end else if (flush) begin
                rdy = (p < total);
                exp = {rdy, v && rdy, 3'b001, (p / w) - 1 == h - 1, 1'b1, 1'b0, 1'b0};
            end else begin
                exp = {1'b1, v, v && (p % w == 1), v && (p % w >= 2), 1'b0,
                       (p / w) == h - 1, 1'b1, 1'b0, 1'b0};
            end
            #1;
            n_vec++;
            if (outs() !== exp) begin
                n_err++;
                $display("FAIL cycle w=%0d h=%0d cyc=%0d got=%b exp=%b (rdy,push,L,C,R,rowM,busy,done,err)",
                         w, h, cyc, outs(), exp);
            end
            n_vec++;
            if (o_new_pixel !== s_pixel) begin
                n_err++;
                $display("FAIL pixel_copy got=%h exp=%h", o_new_pixel, s_pixel);
            end
            if ((o_valid_lpos + o_valid_cpos + o_valid_rpos) > 1) begin
                n_err++;
                $display("FAIL multi_strobe cyc=%0d got=%b exp=at most one",
                         cyc, {o_valid_lpos, o_valid_cpos, o_valid_rpos});
            end
            cl += o_valid_lpos;
            cc += o_valid_cpos;
            cr += o_valid_rpos;
            cp += o_valid_new_pixel;

            // Advance the model
            if (drain_left > 0) begin
                drain_left--;
                if (drain_left == 0) fin = 1;
            end else if (flush) begin
                flush = 0;
                if (p < total) begin
                    if (v) p++;
                end else begin
                    drain_left = 3;
                end
            end else if (v) begin
                if (p % w == w - 1) flush = 1;
                p++;
            end
            cyc++;
            @(negedge clk);
        end
        i_start = 1'b0;
        s_valid = 1'b0;
        #1;
        n_vec++;
        if (outs() !== 9'b0) begin
            n_err++;
            $display("FAIL post_frame_idle got=%b exp=%b", outs(), 9'b0);
        end
        n_vec++;
        if (cl !== h || cc !== h * (w - 2) || cr !== h || cp !== total) begin
            n_err++;
            $display("FAIL frame_counts w=%0d h=%0d got L=%0d C=%0d R=%0d P=%0d exp L=%0d C=%0d R=%0d P=%0d",
                     w, h, cl, cc, cr, cp, h, h * (w - 2), h, total);
        end
    endtask

    task automatic test_bad_start(input int w, input int h);
        @(negedge clk);
        i_start = 1'b1;
        i_width = XB'(w);
        i_height = YB'(h);
        @(negedge clk);
        i_start = 1'b0;
        #1;
        n_vec++;
        if (outs() !== 9'b000000001) begin
            n_err++;
            $display("FAIL bad_start_err w=%0d h=%0d got=%b exp=%b", w, h, outs(), 9'b000000001);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (outs() !== 9'b0) begin
            n_err++;
            $display("FAIL bad_start_after w=%0d h=%0d got=%b exp=%b", w, h, outs(), 9'b0);
        end
    endtask

    task automatic test_basic();
        run_frame(4, 2, 0, 1'b0, -1);
    endtask

    task automatic test_min_width();
        run_frame(2, 1, 0, 1'b0, -1);
    endtask

    task automatic test_gaps();
        run_frame(5, 1, 1, 1'b0, -1);
    endtask

    task automatic test_errors();
        test_bad_start(1, 3);
        test_bad_start(5, 0);
        test_bad_start(0, 2);
        run_frame(3, 2, 0, 1'b1, -1);
    endtask

    task automatic test_abort();
        run_frame(4, 3, 0, 1'b0, 6);
        run_frame(4, 3, 2, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_frame($urandom_range(2, 16), $urandom_range(1, 8), 2, 1'b0, -1);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_min_width();
        test_gaps();
        test_errors();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
